// File: rtl/zad4_char_scroller_pkg.sv
// rtl/zad4_char_scroller_pkg.sv - shared constants and rotate helper for the character scroller
package zad4_pkg;

  localparam int CW    = 2;
  localparam int NCHAR = 4;

  localparam logic [CW-1:0] CH_A = 2'd0;
  localparam logic [CW-1:0] CH_B = 2'd1;
  localparam logic [CW-1:0] CH_C = 2'd2;
  localparam logic [CW-1:0] CH_D = 2'd3;

  localparam logic [CW*NCHAR-1:0] RST_WORD = {CH_A, CH_B, CH_C, CH_D};

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  // Slot 3 sits in the top bits, so a left scroll is a left rotate by one character.
  function automatic logic [CW*NCHAR-1:0] rot_word(input logic [CW*NCHAR-1:0] w,
                                                   input logic                  d);
    if (d == DIR_L) begin
      rot_word = {w[CW*NCHAR-CW-1:0], w[CW*NCHAR-1 -: CW]};
    end else begin
      rot_word = {w[CW-1:0], w[CW*NCHAR-1:CW]};
    end
  endfunction

endpackage

// File: rtl/zad4_char_scroller_if.sv
// rtl/zad4_char_scroller_if.sv - control and character-code bundle between board top and scroller
interface zad4_char_scroller_if;
  import zad4_pkg::*;

  logic                  en;
  logic                  dir;
  logic                  step;
  logic                  load;
  logic [CW*NCHAR-1:0]   load_word;
  logic [CW-1:0]         c3;
  logic [CW-1:0]         c2;
  logic [CW-1:0]         c1;
  logic [CW-1:0]         c0;
  logic [1:0]            offset;
  logic                  tick;

  modport master (
    output en, dir, step, load, load_word,
    input  c3, c2, c1, c0, offset, tick
  );

  modport slave (
    input  en, dir, step, load, load_word,
    output c3, c2, c1, c0, offset, tick
  );

endinterface

// File: rtl/zad4_char_scroller_tick_gen.sv
// rtl/zad4_char_scroller_tick_gen.sv - freezable prescaler producing one pulse every TICK_DIV enabled cycles
module zad4_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic en,
  input  logic clr,
  output logic pt
);

  localparam int                CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign pt = en && (cnt_q == CNT_MAX);

  // clr beats en so a load restarts the period even on the wrap cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = pt ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/zad4_char_scroller.sv
// rtl/zad4_char_scroller.sv - rotates a 4-character word across the digit slots on tick or manual step
module zad4_char_scroller
  import zad4_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  zad4_char_scroller_if.slave  bus
);

  logic [CW*NCHAR-1:0] word_q;
  logic [CW*NCHAR-1:0] word_d;
  logic [1:0]          offset_q;
  logic [1:0]          offset_d;
  logic                tick_q;
  logic                tick_d;
  logic                step_q;
  logic                step_d;
  logic                pt;
  logic                sp;
  logic                rot;

  zad4_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .Clock  (Clock),
    .Resetn (Resetn),
    .en     (bus.en),
    .clr    (bus.load),
    .pt     (pt)
  );

  // Manual steps only count while auto-scroll is off, so the two sources never race.
  assign step_d = bus.step;
  assign sp     = bus.step & ~step_q;
  assign rot    = pt | (sp & ~bus.en);

  always_comb begin
    word_d   = word_q;
    offset_d = offset_q;
    tick_d   = 1'b0;
    if (bus.load) begin
      word_d   = bus.load_word;
      offset_d = 2'd0;
    end else if (rot) begin
      word_d   = rot_word(word_q, bus.dir);
      offset_d = (bus.dir == DIR_L) ? offset_q + 2'd1 : offset_q - 2'd1;
      tick_d   = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      word_q   <= RST_WORD;
      offset_q <= 2'd0;
      tick_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      word_q   <= word_d;
      offset_q <= offset_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
    end
  end

  assign bus.c3     = word_q[7:6];
  assign bus.c2     = word_q[5:4];
  assign bus.c1     = word_q[3:2];
  assign bus.c0     = word_q[1:0];
  assign bus.offset = offset_q;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_zad4_char_scroller.sv
// tb/tb_zad4_char_scroller.sv - directed scoreboard bench for the character scroller
module tb_zad4_char_scroller;

  typedef struct packed {
    logic [7:0] word;
    logic [1:0] off;
    logic       tick;
  } exp_t;

  logic Clock = 1'b0;
  logic Resetn;

  zad4_char_scroller_if bus ();

  zad4_char_scroller #(
    .TICK_DIV (4)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Words written as c3 c2 c1 c0: 0123, 1230, 2301, 3012 and 3210.
  localparam logic [7:0] W0123 = 8'h1B;
  localparam logic [7:0] W1230 = 8'h6C;
  localparam logic [7:0] W2301 = 8'hB1;
  localparam logic [7:0] W3012 = 8'hC6;
  localparam logic [7:0] W3210 = 8'hE4;
  localparam logic [7:0] W2103 = 8'h93;

  task automatic cyc(input logic [7:0] w, input logic [1:0] o, input logic t, input string tag);
    exp_t e;
    exp_t got;
    string g;
    exp_q.push_back('{word: w, off: o, tick: t});
    tag_q.push_back(tag);
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    g = tag_q.pop_front();
    got = '{word: {bus.c3, bus.c2, bus.c1, bus.c0}, off: bus.offset, tick: bus.tick};
    n_tests++;
    assert (got.word === e.word) else begin
      n_fail++;
      $error("FAIL %s word observed=%h expected=%h", g, got.word, e.word);
    end
    n_tests++;
    assert (got.off === e.off) else begin
      n_fail++;
      $error("FAIL %s offset observed=%0d expected=%0d", g, got.off, e.off);
    end
    n_tests++;
    assert (got.tick === e.tick) else begin
      n_fail++;
      $error("FAIL %s tick observed=%b expected=%b", g, got.tick, e.tick);
    end
  endtask

  logic [7:0] left_seq [5];
  logic [7:0] w_exp;
  logic [1:0] o_exp;

  initial begin
    left_seq[0] = W0123;
    left_seq[1] = W1230;
    left_seq[2] = W2301;
    left_seq[3] = W3012;
    left_seq[4] = W0123;

    Resetn        = 1'b0;
    bus.en        = 1'b0;
    bus.dir       = 1'b0;
    bus.step      = 1'b0;
    bus.load      = 1'b0;
    bus.load_word = 8'h00;
    repeat (2) cyc(W0123, 2'd0, 1'b0, "reset");

    Resetn = 1'b1;
    repeat (20) cyc(W0123, 2'd0, 1'b0, "idle");

    // Automatic left scroll: a tick on every fourth enabled cycle.
    bus.en  = 1'b1;
    bus.dir = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      w_exp = left_seq[i / 4];
      o_exp = 2'((i / 4) % 4);
      cyc(w_exp, o_exp, (i % 4) == 0, "auto_left");
    end

    Resetn = 1'b0;
    cyc(W0123, 2'd0, 1'b0, "reset_right");
    Resetn  = 1'b1;
    bus.dir = 1'b1;
    repeat (3) cyc(W0123, 2'd0, 1'b0, "right_wait1");
    cyc(W3012, 2'd3, 1'b1, "right_tick1");
    repeat (3) cyc(W3012, 2'd3, 1'b0, "right_wait2");
    cyc(W2301, 2'd2, 1'b1, "right_tick2");

    // Manual step: one rotation per rising edge, held level ignored.
    Resetn = 1'b0;
    bus.en = 1'b0;
    cyc(W0123, 2'd0, 1'b0, "reset_step");
    Resetn   = 1'b1;
    bus.dir  = 1'b0;
    bus.step = 1'b1;
    cyc(W1230, 2'd1, 1'b1, "step_edge1");
    repeat (4) cyc(W1230, 2'd1, 1'b0, "step_held");
    bus.step = 1'b0;
    cyc(W1230, 2'd1, 1'b0, "step_low");
    bus.step = 1'b1;
    cyc(W2301, 2'd2, 1'b1, "step_edge2");
    bus.step = 1'b0;
    cyc(W2301, 2'd2, 1'b0, "step_low2");

    // Step while enabled is ignored; then freeze the prescaler at count 3.
    bus.en   = 1'b1;
    bus.step = 1'b1;
    cyc(W2301, 2'd2, 1'b0, "step_en1");
    bus.step = 1'b0;
    cyc(W2301, 2'd2, 1'b0, "step_en2");
    bus.step = 1'b1;
    cyc(W2301, 2'd2, 1'b0, "step_en3");
    bus.en   = 1'b0;
    bus.step = 1'b0;
    repeat (3) cyc(W2301, 2'd2, 1'b0, "frozen");
    bus.en = 1'b1;
    cyc(W3012, 2'd3, 1'b1, "resume");

    // Load coincident with a prescaler pulse: load wins, period restarts.
    repeat (3) cyc(W3012, 2'd3, 1'b0, "pre_load");
    bus.load      = 1'b1;
    bus.load_word = W3210;
    cyc(W3210, 2'd0, 1'b0, "load_vs_pt");
    bus.load = 1'b0;
    repeat (3) cyc(W3210, 2'd0, 1'b0, "post_load");
    cyc(W2103, 2'd1, 1'b1, "post_load_tick");

    // Reset at count 2 together with load: reset wins and clears the prescaler.
    repeat (2) cyc(W2103, 2'd1, 1'b0, "pre_reset");
    Resetn   = 1'b0;
    bus.load = 1'b1;
    cyc(W0123, 2'd0, 1'b0, "reset_vs_load");
    Resetn   = 1'b1;
    bus.load = 1'b0;
    repeat (3) cyc(W0123, 2'd0, 1'b0, "post_reset");
    cyc(W1230, 2'd1, 1'b1, "post_reset_tick");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
